// File: rtl/lieat_ifu_bpu2lvl_if.sv
// ----------------------------------------------------------------------------
// lieat_ifu_bpu2lvl_if
// Bundle of the request / prediction / update / ready signals of the two-level
// branch predictor.
//   master : fetch-side agent, drives requests and resolved-branch updates
//   slave  : the predictor itself
// Signals
//   req_valid, req_index, req_bxx   prediction request
//   prd_valid, prd_taken, prd_hist  prediction result (one cycle later)
//   upd_en, upd_index, upd_taken, upd_hist  resolved-branch update
//   ready                           table initialisation finished
// ----------------------------------------------------------------------------
interface lieat_ifu_bpu2lvl_if #(
  parameter int IDX_W = 5,
  parameter int BHR_W = 2
);
  logic             req_valid;
  logic [IDX_W-1:0] req_index;
  logic             req_bxx;
  logic             prd_valid;
  logic             prd_taken;
  logic [BHR_W-1:0] prd_hist;
  logic             upd_en;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic [BHR_W-1:0] upd_hist;
  logic             ready;

  modport master (
    output req_valid, req_index, req_bxx,
    output upd_en, upd_index, upd_taken, upd_hist,
    input  prd_valid, prd_taken, prd_hist, ready
  );

  modport slave (
    input  req_valid, req_index, req_bxx,
    input  upd_en, upd_index, upd_taken, upd_hist,
    output prd_valid, prd_taken, prd_hist, ready
  );
endinterface

// File: rtl/lieat_ifu_bpu2lvl.sv
// ----------------------------------------------------------------------------
// lieat_ifu_bpu2lvl
// Two-level adaptive branch direction predictor. A pattern history table of
// saturating counters is indexed by row and by a branch history, which is
// either kept per row (MODE 0) or as one global register (MODE 1).
// After reset the table is walked one row per cycle back to weakly-not-taken;
// requests and updates are ignored until ready rises.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lieat_ifu_bpu2lvl_if.slave (request, prediction, update, ready)
// ----------------------------------------------------------------------------
module lieat_ifu_bpu2lvl #(
  parameter int IDX_W = 5,
  parameter int BHR_W = 2,
  parameter int CNT_W = 2,
  parameter int MODE  = 0
) (
  input logic                clk,
  input logic                rst,
  lieat_ifu_bpu2lvl_if.slave bus
);

  localparam int ROWS = 1 << IDX_W;
  localparam int COLS = 1 << BHR_W;
  localparam logic [CNT_W-1:0] WNT     = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic             run;

  // Each row is packed so initialisation rewrites it in a single assignment.
  logic [COLS-1:0][CNT_W-1:0] pht [ROWS];
  logic [BHR_W-1:0]           bhr [ROWS];
  logic [BHR_W-1:0]           ghr_q;

  logic [BHR_W-1:0] req_hist_p0;
  logic [CNT_W-1:0] req_cnt_p0;
  logic             req_fire_p0;
  logic             upd_fire_p0;
  logic [CNT_W-1:0] upd_cnt_p0;
  logic [BHR_W-1:0] upd_cur_hist_p0;
  logic [BHR_W-1:0] upd_nxt_hist_p0;

  logic             prd_vld_p1;
  logic             prd_taken_p1;
  logic [BHR_W-1:0] prd_hist_p1;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic             up);
    if (up) return (c == CNT_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  // Shift-in works for BHR_W = 1 too: the shifted value is 0, LSB takes t.
  function automatic logic [BHR_W-1:0] hist_shift(input logic [BHR_W-1:0] h,
                                                  input logic             t);
    logic [BHR_W-1:0] s;
    s    = h << 1;
    s[0] = t;
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign run = (state_q == RUN);

  // Stage p0: table read for request and update (pre-update values).
  assign req_fire_p0     = run & bus.req_valid;
  assign upd_fire_p0     = run & bus.upd_en;
  assign req_hist_p0     = (MODE == 1) ? ghr_q : bhr[bus.req_index];
  assign req_cnt_p0      = pht[bus.req_index][req_hist_p0];
  assign upd_cnt_p0      = pht[bus.upd_index][bus.upd_hist];
  assign upd_cur_hist_p0 = (MODE == 1) ? ghr_q : bhr[bus.upd_index];
  assign upd_nxt_hist_p0 = hist_shift(upd_cur_hist_p0, bus.upd_taken);

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      pht[init_cnt_q] <= {COLS{WNT}};
      if (MODE == 0) bhr[init_cnt_q] <= '0;
    end else if (bus.upd_en) begin
      pht[bus.upd_index][bus.upd_hist] <= sat_step(upd_cnt_p0, bus.upd_taken);
      if (MODE == 0) bhr[bus.upd_index] <= upd_nxt_hist_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            ghr_q <= '0;
    else if (upd_fire_p0 && MODE == 1) ghr_q <= upd_nxt_hist_p0;
  end

  // Stage p1: registered prediction, held while no request fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      prd_vld_p1   <= 1'b0;
      prd_taken_p1 <= 1'b0;
      prd_hist_p1  <= '0;
    end else begin
      prd_vld_p1 <= req_fire_p0;
      if (req_fire_p0) begin
        prd_taken_p1 <= bus.req_bxx & req_cnt_p0[CNT_W-1];
        prd_hist_p1  <= req_hist_p0;
      end
    end
  end

  assign bus.prd_valid = prd_vld_p1;
  assign bus.prd_taken = prd_taken_p1;
  assign bus.prd_hist  = prd_hist_p1;
  assign bus.ready     = run;

endmodule

// File: doc/lieat_ifu_bpu2lvl.md
LIEAT_IFU_BPU2LVL -- requirements
Module: lieat_ifu_bpu2lvl

Interface
REQ-001 The block SHALL have parameter IDX_W, default 5; index width, giving 2^IDX_W predictor rows.
REQ-002 The block SHALL have parameter BHR_W, default 2; history width, giving 2^BHR_W counters per row; BHR_W >= 1.
REQ-003 The block SHALL have parameter CNT_W, default 2; saturating counter width; CNT_W >= 2.
REQ-004 The block SHALL have parameter MODE, default 0; 0 = per-row local history (BHR table), 1 = single shared global history register (GHR).
REQ-005 The block SHALL have a single clock, clk, input, 1 bit; all state updates on its rising edge.
REQ-006 The block SHALL have reset rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 The block SHALL have req_valid, input, 1 bit; a prediction request is present this cycle.
REQ-008 The block SHALL have req_index, input, IDX_W bits; row to predict.
REQ-009 The block SHALL have req_bxx, input, 1 bit; the requesting instruction is a conditional branch.
REQ-010 The block SHALL have prd_valid, output, 1 bit; a prediction result is present.
REQ-011 The block SHALL have prd_taken, output, 1 bit; predicted direction.
REQ-012 The block SHALL have prd_hist, output, BHR_W bits; history snapshot used for the prediction, returned later on upd_hist.
REQ-013 The block SHALL have upd_en, input, 1 bit; a resolved-branch update is present.
REQ-014 The block SHALL have upd_index, input, IDX_W bits; row to update.
REQ-015 The block SHALL have upd_taken, input, 1 bit; resolved direction.
REQ-016 The block SHALL have upd_hist, input, BHR_W bits; history snapshot from the original prediction.
REQ-017 The block SHALL have ready, output, 1 bit; high when initialisation is complete.

Function
REQ-018 The block SHALL hold PHT[row][hist], 2^IDX_W x 2^BHR_W counters of CNT_W bits each.
REQ-019 Weakly-not-taken (WNT) SHALL be 2^(CNT_W-1)-1; taken SHALL be counter MSB = 1.
REQ-020 The FSM SHALL have two states, INIT and RUN; rst SHALL force INIT with init_cnt = 0 from any state, including mid-INIT.
REQ-021 In INIT, each cycle SHALL write every PHT counter of row init_cnt to WNT and, when MODE = 0, BHR[init_cnt] to 0, then increment init_cnt.
REQ-022 The FSM SHALL transition from INIT to RUN in the cycle after row 2^IDX_W-1 is written; ready SHALL be 1 only in RUN.
REQ-023 In INIT, req_valid and upd_en SHALL be ignored and prd_valid SHALL be 0.
REQ-024 Prediction latency SHALL be 1 cycle: RUN & req_valid at edge N gives prd_valid = 1 during cycle N+1; prd_valid = 0 otherwise.
REQ-025 The history used for prediction SHALL be h = BHR[req_index] (MODE 0) or GHR (MODE 1), and prd_hist SHALL equal h.
REQ-026 prd_taken SHALL equal req_bxx & MSB(PHT[req_index][h]).
REQ-027 When prd_valid = 0, prd_taken and prd_hist SHALL hold their last values.
REQ-028 On RUN & upd_en, PHT[upd_index][upd_hist] SHALL increment if upd_taken, else decrement, saturating at 0 and 2^CNT_W-1.
REQ-029 On RUN & upd_en, the current stored history for upd_index (MODE 0) or GHR (MODE 1) SHALL shift left and take upd_taken in the LSB; for BHR_W = 1 it SHALL become upd_taken.
REQ-030 When a request and an update occur in the same cycle, including to the same row, the prediction SHALL use pre-update state (read-before-write) and the update SHALL be applied normally.
REQ-031 At most one update per cycle SHALL be applied; no queuing.

Reset
REQ-032 While rst = 1, on each clock edge: prd_valid = 0, prd_taken = 0, prd_hist = 0, ready = 0, GHR = 0, state = INIT, init_cnt = 0.
REQ-033 PHT and BHR contents SHALL be defined only after INIT completes.

Verification
REQ-034 Reset timing (defaults): rst high 1 cycle then low -> ready = 0 for 32 cycles, then 1; requests issued during INIT give prd_valid = 0.
REQ-035 Cold predict: req idx 3, bxx = 1 -> next cycle prd_valid = 1, prd_taken = 0, prd_hist = 2'b00.
REQ-036 Local training: upd idx 3 taken hist 00, twice.
  - Required: PHT[3][00] = 2'b11, BHR[3] = 2'b11.
  - Then predict idx 3: prd_hist = 11, prd_taken = 0.
  - Then two updates hist 11 taken; predict idx 3: prd_taken = 1.
REQ-037 Saturation and bxx gating:
  - 5 taken updates idx 7 hist 00 -> PHT[7][00] = 2'b11.
  - 1 not-taken update -> PHT[7][00] = 2'b10.
  - req_bxx = 0 -> prd_taken = 0.
REQ-038 Collision: same cycle req idx 3 and upd idx 3 taken from a cold state -> prd_hist = 00 and prd_taken = 0; the following predict gives prd_hist = 01.
REQ-039 MODE = 1: upd idx 1 taken then predict idx 9 -> prd_hist = 2'b01.
REQ-040 Mid-INIT reset: rst asserted at INIT cycle 10 -> ready rises 32 cycles after its release.
